uart_tx_feeder: RTL

- Upstream stage for UART_driver: buffers bytes from a valid/ready producer in a FIFO, computes the parity bit, and launches one UART frame at a time.
- Drives the driver's UART_Start and data_in[8:0]; observes its UART_Ready and UART_Busy.
- Enforces a programmable idle gap between frames and flags lost launch handshakes.

---
 rtl/uart_tx_feeder.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and launches one parity-tagged UART frame at a time
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   s_valid    producer byte valid
//   s_data     producer byte
//   s_ready    FIFO can accept (not full)
//   UART_Start one-cycle launch pulse to the driver
//   tx_data    {parity, byte} to the driver data_in
//   UART_Ready driver idle
//   UART_Busy  driver transmitting
//   fifo_count current FIFO occupancy
//   fifo_empty occupancy is zero
//   fifo_full  occupancy is DEPTH
//   start_err  sticky: a launch was never acknowledged by UART_Busy
//   err_clr    synchronous clear of start_err
module uart_tx_feeder #(
   parameter int DEPTH        = 16,
   parameter bit PARITY_EN    = 1'b1,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int GAP_CYCLES   = 0,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   input  logic [7:0]             s_data,
   output logic                   s_ready,
   output logic                   UART_Start,
   output logic [8:0]             tx_data,
   input  logic                   UART_Ready,
   input  logic                   UART_Busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   fifo_empty,
   output logic                   fifo_full,
   output logic                   start_err,
   input  logic                   err_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(BUSY_TIMEOUT + 2);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [AW:0]   FULL     = DEPTH[AW:0];
   localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_e;
   state_e        state_q;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   count_q, count_d;
   logic [TW-1:0] tmo_q;
   logic [GW-1:0] gap_q;
   logic          start_q, err_q;
   logic [8:0]    tx_q;
   logic          push, pop, par;
   logic [7:0]    head;
   assign fifo_count = count_q;
   assign fifo_empty = count_q == '0;
   assign fifo_full  = count_q == FULL;
   assign s_ready    = !fifo_full;
   assign UART_Start = start_q;
   assign tx_data    = tx_q;
   assign start_err  = err_q;
   assign push = s_valid && s_ready;
   // the only pop is the launch itself, so the freed slot is writable from the next cycle
   assign pop  = state_q == IDLE && !fifo_empty && UART_Ready;
   assign head = mem_q[rd_q];
   assign par  = PARITY_EN ? (^head) ^ PARITY_ODD : 1'b1;
   always_comb count_d = push && !pop ? count_q + 1'b1 : pop && !push ? count_q - 1'b1 : count_q;
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= s_data;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         tmo_q   <= '0;
         gap_q   <= '0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         tx_q    <= 9'h1FF;
      end else begin
         count_q <= count_d;
         start_q <= 1'b0;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         // a timeout below overrides this clear in the same cycle
         if (err_clr) err_q <= 1'b0;
         case (state_q)
            IDLE:
               if (pop) begin
                  tx_q    <= {par, head};
                  start_q <= 1'b1;
                  state_q <= LAUNCH;
               end
            LAUNCH: begin
               tmo_q   <= '0;
               state_q <= WAIT_BUSY;
            end
            WAIT_BUSY:
               if (UART_Busy) state_q <= WAIT_DONE;
               else if (tmo_q == TMO_LAST) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else tmo_q <= tmo_q + 1'b1;
            WAIT_DONE:
               if (UART_Ready) begin
                  gap_q   <= GAP_LOAD;
                  state_q <= GAP_CYCLES > 0 ? GAP : IDLE;
               end
            GAP:
               if (gap_q <= GW'(1)) state_q <= IDLE;
               else gap_q <= gap_q - 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
